dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store path (port C) and a debug/DMA loader (port D) that preloads and inspects memory.
- Sits between the core datapath and the data memory.
- Performs round-robin arbitration with an optional bounded lock for bursts.
- Returns read data one cycle after grant and gives the core a stall indication.

Parameters:
- AW, 32, address width of both ports and the memory.
- DW, 32, data width.
- MAX_LOCK, 8, maximum consecutive locked grants before a waiting requester is forced in (≥1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- c_req  in  1  core access request, held until c_gnt
- c_we  in  1  core write enable (1 = store)
- c_lock  in  1  core requests to keep ownership after this grant
- c_addr  in  AW  core byte address
- c_wd  in  DW  core write data
- c_gnt  out  1  core granted this cycle
- c_stall  out  1  c_req & ~c_gnt
- c_rvalid  out  1  core read data valid
- c_rdata  out  DW  core read data
- d_req, d_we, d_lock, d_addr, d_wd, d_gnt, d_rvalid, d_rdata  same as the c_ signals, for the DMA/debug port
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wd  out  DW  memory write data
- mem_rd  in  DW  memory combinational read data

Behaviour:
- State registers:
  - last: last granted port, C or D.
  - owner: NONE, C or D.
  - lock_cnt: ceil(log2(MAX_LOCK+1)) bits.
- Reset values (rst low, async): last=D, so C wins the first tie. owner=NONE, lock_cnt=0, c_rvalid=d_rvalid=0, c_rdata=d_rdata=0.
- mem_we is gated combinationally to 0 while rst is low.
- Grant decision is combinational in the request cycle, at most one grant per cycle:
  - owner=NONE: only one req → grant it. Both → grant the port ≠ last. Neither → no grant.
  - owner=X and X_req=1 and X_lock=1:
    - If lock_cnt < MAX_LOCK, or the other port is idle → grant X.
    - If lock_cnt == MAX_LOCK and the other port is requesting → forced release: grant the other port.
  - owner=X with X_req=0 or X_lock=0: lock is released and the cycle arbitrates as owner=NONE. last still applies, so the other port wins any tie.
- On each rising edge with a grant to G:
  - last ← G.
  - If G_lock=1 and this was not a forced release: owner ← G. lock_cnt ← lock_cnt+1 when G was already owner, else 1.
  - Otherwise owner ← NONE, lock_cnt ← 0.
- On an edge with no grant: owner ← NONE, lock_cnt ← 0.
- Memory mux:
  - mem_addr and mem_wd come from the granted port, and are 0 when no grant.
  - mem_we = grant & granted_we.
  - Writes complete at the edge ending the grant cycle.
- Read return, latency 1:
  - X_rvalid ← X_gnt & ~X_we.
  - X_rdata ← mem_rd when X_gnt & ~X_we, otherwise it holds its value.
  - Write grants never raise rvalid.
- A requester must hold req, we, addr and wd stable until granted. The arbiter does not buffer requests.
- A back-to-back same-port grant is allowed every cycle; throughput is 1 access per cycle.
- Reset mid-operation clears lock and rvalid immediately. An in-flight write in that cycle is dropped.

Decomposition:
- Shared package holds:
  - port id encoding: PORT_C=1'b0, PORT_D=1'b1.
  - owner encoding: OWN_NONE=2'd0, OWN_C=2'd1, OWN_D=2'd2.
  - default widths.
- One sub-module, rr_lock_arb: the 2-way round-robin and lock/counter logic, producing grant vector and next-state.
- The top level holds the data mux and read-return registers.

Test Plan:
- Reset: hold rst=0 with c_req=1, c_we=1 → mem_we=0 and all rvalid=0. Release rst and assert both req on the same cycle → c_gnt=1, d_gnt=0.
- Round robin: both ports request reads continuously at addresses 0x10 and 0x20 → grants alternate C, D, C, D. Each rvalid rises the cycle after its grant, with rdata equal to the preloaded words.
- Core stall: d_req=1 with d_lock=1 at cycle 0; c_req=1 at cycle 1 → c_stall=1 until forced release. With MAX_LOCK=8, c_gnt rises on the 9th cycle after D's first grant. d_gnt=0 that cycle.
- Voluntary lock release: D drops d_lock after 3 locked grants while C waits → C is granted the next cycle and owner=NONE.
- Write/read ordering: C writes 0xDEADBEEF to 0x40, then D reads 0x40 the next cycle → d_rvalid=1 with d_rdata=0xDEADBEEF, and c_rvalid stays 0.
- Async reset mid-lock: drop rst during a D locked burst → d_gnt=0 and mem_we=0 immediately. After release, C wins the first tie.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared encodings and default widths for the data-memory
// arbiter slice (port ids, lock-owner states, width defaults, counter sizing).
package dmem_arbiter_pkg;

  localparam int unsigned DEF_AW       = 32;
  localparam int unsigned DEF_DW       = 32;
  localparam int unsigned DEF_MAX_LOCK = 8;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } port_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_C    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Lock counter must be able to hold the value MAX_LOCK itself.
  function automatic int unsigned lock_cnt_width(input int unsigned max_lock);
    return $clog2(max_lock + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the core port (c_*), debug/DMA port (d_*) and
// single-port memory (mem_*) signals.
//   slave  : arbiter side (takes requests, drives grants/read data/memory bus)
//   master : environment side (requesters and the memory itself)
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
);

  logic          c_req;
  logic          c_we;
  logic          c_lock;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wd;
  logic          c_gnt;
  logic          c_stall;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;

  logic          d_req;
  logic          d_we;
  logic          d_lock;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wd;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  c_req, c_we, c_lock, c_addr, c_wd,
    output c_gnt, c_stall, c_rvalid, c_rdata,
    input  d_req, d_we, d_lock, d_addr, d_wd,
    output d_gnt, d_rvalid, d_rdata,
    output mem_we, mem_addr, mem_wd,
    input  mem_rd
  );

  modport master (
    output c_req, c_we, c_lock, c_addr, c_wd,
    input  c_gnt, c_stall, c_rvalid, c_rdata,
    output d_req, d_we, d_lock, d_addr, d_wd,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_we, mem_addr, mem_wd,
    output mem_rd
  );

endinterface

// File: rtl/dmem_arbiter_rr_lock_arb.sv
// rr_lock_arb: two-way round-robin arbiter with a bounded ownership lock.
//   clk, rst          : clock, async active-low reset
//   c_req/c_lock      : core request and keep-ownership hint
//   d_req/d_lock      : DMA/debug request and keep-ownership hint
//   c_gnt/d_gnt       : one-hot-or-zero grant, combinational in request cycle
module rr_lock_arb
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic clk,
  input  logic rst,
  input  logic c_req,
  input  logic c_lock,
  input  logic d_req,
  input  logic d_lock,
  output logic c_gnt,
  output logic d_gnt
);

  localparam int unsigned    CW      = lock_cnt_width(MAX_LOCK);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_LOCK);

  port_e         last_q, last_d;
  owner_e        owner_q, owner_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  logic          forced;
  logic          c_hold, d_hold;
  logic [CW-1:0] cnt_inc;

  always_comb begin
    c_gnt  = 1'b0;
    d_gnt  = 1'b0;
    forced = 1'b0;
    c_hold = (owner_q == OWN_C) && c_req && c_lock;
    d_hold = (owner_q == OWN_D) && d_req && d_lock;

    // Grants are suppressed while reset is asserted so nothing reaches memory.
    if (!rst) begin
      c_gnt = 1'b0;
    end else if (c_hold) begin
      if ((lock_cnt_q < MAX_CNT) || !d_req) begin
        c_gnt = 1'b1;
      end else begin
        d_gnt  = 1'b1;
        forced = 1'b1;
      end
    end else if (d_hold) begin
      if ((lock_cnt_q < MAX_CNT) || !c_req) begin
        d_gnt = 1'b1;
      end else begin
        c_gnt  = 1'b1;
        forced = 1'b1;
      end
    end else if (c_req && d_req) begin
      if (last_q == PORT_C) d_gnt = 1'b1;
      else                  c_gnt = 1'b1;
    end else if (c_req) begin
      c_gnt = 1'b1;
    end else if (d_req) begin
      d_gnt = 1'b1;
    end

    // Counter saturates at MAX_LOCK: values above it behave identically in
    // the compare above, and this keeps it inside CW bits for any MAX_LOCK.
    cnt_inc = (lock_cnt_q == MAX_CNT) ? MAX_CNT : lock_cnt_q + CW'(1);

    last_d     = last_q;
    owner_d    = OWN_NONE;
    lock_cnt_d = '0;
    if (c_gnt) begin
      last_d = PORT_C;
      if (c_lock && !forced) begin
        owner_d    = OWN_C;
        lock_cnt_d = (owner_q == OWN_C) ? cnt_inc : CW'(1);
      end
    end else if (d_gnt) begin
      last_d = PORT_D;
      if (d_lock && !forced) begin
        owner_d    = OWN_D;
        lock_cnt_d = (owner_q == OWN_D) ? cnt_inc : CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q     <= PORT_D;
      owner_q    <= OWN_NONE;
      lock_cnt_q <= '0;
    end else begin
      last_q     <= last_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the core (c_*) and a
// debug/DMA loader (d_*). Round-robin with bounded lock; read data returns one
// cycle after grant.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : dmem_arbiter_if.slave (requests, grants, stall, read return, memory)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic               clk,
  input  logic               rst,
  dmem_arbiter_if.slave      bus
);

  logic          c_gnt, d_gnt;
  logic          mem_we_mux;
  logic [AW-1:0] mem_addr_mux;
  logic [DW-1:0] mem_wd_mux;

  logic          c_rvalid_q, c_rvalid_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  rr_lock_arb #(.MAX_LOCK(MAX_LOCK)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .c_req  (bus.c_req),
    .c_lock (bus.c_lock),
    .d_req  (bus.d_req),
    .d_lock (bus.d_lock),
    .c_gnt  (c_gnt),
    .d_gnt  (d_gnt)
  );

  // Grants are already zero during reset, which also keeps mem_we low.
  always_comb begin
    mem_we_mux   = 1'b0;
    mem_addr_mux = '0;
    mem_wd_mux   = '0;
    if (c_gnt) begin
      mem_we_mux   = bus.c_we;
      mem_addr_mux = bus.c_addr;
      mem_wd_mux   = bus.c_wd;
    end else if (d_gnt) begin
      mem_we_mux   = bus.d_we;
      mem_addr_mux = bus.d_addr;
      mem_wd_mux   = bus.d_wd;
    end
  end

  always_comb begin
    c_rvalid_d = c_gnt & ~bus.c_we;
    d_rvalid_d = d_gnt & ~bus.d_we;
    c_rdata_d  = c_rvalid_d ? bus.mem_rd : c_rdata_q;
    d_rdata_d  = d_rvalid_d ? bus.mem_rd : d_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      c_rvalid_q <= c_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      c_rdata_q  <= c_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.c_gnt    = c_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.c_stall  = bus.c_req & ~c_gnt;
  assign bus.c_rvalid = c_rvalid_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.c_rdata  = c_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.mem_we   = mem_we_mux;
  assign bus.mem_addr = mem_addr_mux;
  assign bus.mem_wd   = mem_wd_mux;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven and hand-sequenced checks of dmem_arbiter
// (MAX_LOCK=8) against a small memory and a read-data scoreboard.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Single-port memory: combinational read, write at clock edge.
  logic [31:0] mem [0:255];
  assign bus.mem_rd = mem[bus.mem_addr[9:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wd;

  typedef struct {
    logic        c_req, c_we, c_lock;
    logic [31:0] c_addr, c_wd;
    logic        d_req, d_we, d_lock;
    logic [31:0] d_addr, d_wd;
    logic        gc, gd;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] c_q [$];
  logic [31:0] d_q [$];
  logic        exp_c_rv = 1'b0;
  logic        exp_d_rv = 1'b0;

  function automatic vec_t mk(input logic cr, cw, cl, input logic [31:0] ca, cwd,
                              input logic dr, dw, dl, input logic [31:0] da, dwd,
                              input logic gc, gd);
    vec_t v;
    v.c_req = cr; v.c_we = cw; v.c_lock = cl; v.c_addr = ca; v.c_wd = cwd;
    v.d_req = dr; v.d_we = dw; v.d_lock = dl; v.d_addr = da; v.d_wd = dwd;
    v.gc = gc; v.gd = gd;
    return v;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t t);
    bus.c_req = t.c_req; bus.c_we = t.c_we; bus.c_lock = t.c_lock;
    bus.c_addr = t.c_addr; bus.c_wd = t.c_wd;
    bus.d_req = t.d_req; bus.d_we = t.d_we; bus.d_lock = t.d_lock;
    bus.d_addr = t.d_addr; bus.d_wd = t.d_wd;
  endtask

  // Called at posedge+1; applies one cycle and returns at the next posedge+1.
  task automatic run_vec(input vec_t t, input string tag);
    logic [31:0] e_addr, e_wd;
    logic        e_we;
    drive(t);
    @(negedge clk);
    chk({tag, ".c_rvalid"}, 32'(bus.c_rvalid), 32'(exp_c_rv));
    if (exp_c_rv && c_q.size() > 0) chk({tag, ".c_rdata"}, bus.c_rdata, c_q.pop_front());
    chk({tag, ".d_rvalid"}, 32'(bus.d_rvalid), 32'(exp_d_rv));
    if (exp_d_rv && d_q.size() > 0) chk({tag, ".d_rdata"}, bus.d_rdata, d_q.pop_front());
    chk({tag, ".c_gnt"}, 32'(bus.c_gnt), 32'(t.gc));
    chk({tag, ".d_gnt"}, 32'(bus.d_gnt), 32'(t.gd));
    chk({tag, ".c_stall"}, 32'(bus.c_stall), 32'(t.c_req & ~t.gc));
    e_we   = t.gc ? t.c_we   : t.gd ? t.d_we   : 1'b0;
    e_addr = t.gc ? t.c_addr : t.gd ? t.d_addr : 32'h0;
    e_wd   = t.gc ? t.c_wd   : t.gd ? t.d_wd   : 32'h0;
    chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'(e_we));
    chk({tag, ".mem_addr"}, bus.mem_addr, e_addr);
    chk({tag, ".mem_wd"}, bus.mem_wd, e_wd);
    exp_c_rv = t.gc & ~t.c_we;
    exp_d_rv = t.gd & ~t.d_we;
    if (exp_c_rv) c_q.push_back(ref_rd(t.c_addr));
    if (exp_d_rv) d_q.push_back(ref_rd(t.d_addr));
    if (t.gc & t.c_we) ref_mem[t.c_addr] = t.c_wd;
    if (t.gd & t.d_we) ref_mem[t.d_addr] = t.d_wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [10];
    vec_t idle;
    idle = mk(0,0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0, 0,0);

    //        c: req we lk addr   wd             d: req we lk addr   wd            gc gd
    tbl[0] = mk(1,1,0,32'h10,32'h11111111, 1,1,0,32'h20,32'h22222222, 1,0);
    tbl[1] = mk(0,0,0,32'h0 ,32'h0       , 1,1,0,32'h20,32'h22222222, 0,1);
    tbl[2] = mk(0,0,0,32'h0 ,32'h0       , 1,1,0,32'h30,32'h33333333, 0,1);
    tbl[3] = mk(0,0,0,32'h0 ,32'h0       , 1,1,0,32'h50,32'h50505050, 0,1);
    tbl[4] = mk(0,0,0,32'h0 ,32'h0       , 1,1,0,32'h24,32'h44444444, 0,1);
    tbl[5] = mk(1,0,0,32'h10,32'h0       , 1,0,0,32'h20,32'h0       , 1,0);
    tbl[6] = mk(1,0,0,32'h10,32'h0       , 1,0,0,32'h20,32'h0       , 0,1);
    tbl[7] = mk(1,0,0,32'h10,32'h0       , 1,0,0,32'h20,32'h0       , 1,0);
    tbl[8] = mk(1,0,0,32'h10,32'h0       , 1,0,0,32'h20,32'h0       , 0,1);
    tbl[9] = idle;

    // Reset held with a pending core write.
    rst = 1'b0;
    drive(mk(1,1,0,32'h10,32'hFFFFFFFF, 0,0,0,32'h0,32'h0, 0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.mem_we",   32'(bus.mem_we),   32'h0);
    chk("rst.c_gnt",    32'(bus.c_gnt),    32'h0);
    chk("rst.c_rvalid", 32'(bus.c_rvalid), 32'h0);
    chk("rst.d_rvalid", 32'(bus.d_rvalid), 32'h0);
    chk("rst.c_rdata",  bus.c_rdata,       32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Preload writes (C wins the first tie), then round-robin reads.
    for (int unsigned i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Core stall under a D lock: forced release on the 9th cycle.
    run_vec(mk(0,0,0,32'h0,32'h0, 1,0,1,32'h30,32'h0, 0,1), "stall0");
    for (int unsigned i = 1; i < 8; i++)
      run_vec(mk(1,0,0,32'h10,32'h0, 1,0,1,32'h30,32'h0, 0,1), $sformatf("stall%0d", i));
    run_vec(mk(1,0,0,32'h10,32'h0, 1,0,1,32'h30,32'h0, 1,0), "stall8");
    run_vec(mk(0,0,0,32'h0,32'h0, 1,0,1,32'h30,32'h0, 0,1), "stall9");
    run_vec(idle, "stall_idle");

    // Voluntary release after 3 locked grants.
    run_vec(mk(0,0,0,32'h0 ,32'h0, 1,0,1,32'h20,32'h0, 0,1), "vol0");
    run_vec(mk(1,0,0,32'h14,32'h0, 1,0,1,32'h20,32'h0, 0,1), "vol1");
    run_vec(mk(1,0,0,32'h14,32'h0, 1,0,1,32'h20,32'h0, 0,1), "vol2");
    run_vec(mk(1,0,0,32'h14,32'h0, 1,0,0,32'h20,32'h0, 1,0), "vol3");
    run_vec(mk(1,0,0,32'h10,32'h0, 1,0,0,32'h20,32'h0, 0,1), "vol4");
    run_vec(idle, "vol_idle");

    // Write by C then read by D of the same word.
    run_vec(mk(1,1,0,32'h40,32'hDEADBEEF, 0,0,0,32'h0,32'h0, 1,0), "wr0");
    run_vec(mk(0,0,0,32'h0,32'h0, 1,0,0,32'h40,32'h0, 0,1), "rd1");
    run_vec(idle, "rd_idle");

    // Async reset in the middle of a locked D burst.
    run_vec(mk(0,0,0,32'h0,32'h0, 1,0,1,32'h10,32'h0, 0,1), "rl0");
    run_vec(mk(0,0,0,32'h0,32'h0, 1,0,1,32'h10,32'h0, 0,1), "rl1");
    drive(mk(0,0,0,32'h0,32'h0, 1,1,1,32'h50,32'h55555555, 0,1));
    #1;
    chk("rl2.d_gnt_pre",  32'(bus.d_gnt),  32'h1);
    chk("rl2.mem_we_pre", 32'(bus.mem_we), 32'h1);
    rst = 1'b0;
    #1;
    chk("rl2.d_gnt",    32'(bus.d_gnt),    32'h0);
    chk("rl2.mem_we",   32'(bus.mem_we),   32'h0);
    chk("rl2.d_rvalid", 32'(bus.d_rvalid), 32'h0);
    exp_c_rv = 1'b0;
    exp_d_rv = 1'b0;
    c_q.delete();
    d_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_vec(mk(1,0,0,32'h10,32'h0, 1,0,0,32'h50,32'h0, 1,0), "post0");
    run_vec(mk(0,0,0,32'h0,32'h0, 1,0,0,32'h50,32'h0, 0,1), "post1");
    run_vec(idle, "post_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
